// File: rtl/rf_bank.sv
// Per-core cell cache: one entry per core, serving one scheduler command at a time.
// Misses are filled through a single memory read port, and FLUSH writes back through the write port.
module rf_bank #(
  parameter  int NCORES = 4,
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 16,
  localparam int CW     = $clog2(NCORES),
  localparam int EW     = 3 + ADDR_W + DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CW-1:0]        cmd_core,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_ptr,
  input  logic [DATA_W-1:0]    cmd_data,
  output logic                 done,
  output logic                 hit,
  output logic                 err,
  output logic                 mem_rd_valid,
  input  logic                 mem_rd_ready,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic                 mem_resp_valid,
  input  logic [DATA_W-1:0]    mem_resp_data,
  output logic                 mem_wr_valid,
  input  logic                 mem_wr_ready,
  output logic [ADDR_W-1:0]    mem_wr_addr,
  output logic [DATA_W-1:0]    mem_wr_data,
  output logic [NCORES*EW-1:0] rf_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_LOCK  = 2'b10,
    OP_FLUSH = 2'b11
  } op_e;

  state_e state_q, state_d;
  logic [CW-1:0] cur_q, cur_d;

  logic [NCORES-1:0]             valid_q, valid_d;
  logic [NCORES-1:0]             retr_q, retr_d;
  logic [NCORES-1:0]             lock_q, lock_d;
  logic [NCORES-1:0][ADDR_W-1:0] tag_q, tag_d;
  logic [NCORES-1:0][DATA_W-1:0] val_q, val_d;

  logic              done_q, done_d;
  logic              hit_q, hit_d;
  logic              err_q, err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    valid_d    = valid_q;
    retr_d     = retr_q;
    lock_d     = lock_q;
    tag_d      = tag_q;
    val_d      = val_q;
    done_d     = 1'b0;
    hit_d      = 1'b0;
    err_d      = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_d = cmd_core;
          case (op_e'(cmd_op))
            OP_LOAD: begin
              if (valid_q[cmd_core] && (tag_q[cmd_core] == cmd_ptr)) begin
                state_d = DONE;
                done_d  = 1'b1;
                hit_d   = 1'b1;
              end else if (lock_q[cmd_core] && (tag_q[cmd_core] != cmd_ptr)) begin
                state_d = DONE;
                done_d  = 1'b1;
                err_d   = 1'b1;
              end else begin
                valid_d[cmd_core] = 1'b0;
                retr_d[cmd_core]  = 1'b1;
                tag_d[cmd_core]   = cmd_ptr;
                rd_valid_d        = 1'b1;
                rd_addr_d         = cmd_ptr;
                state_d           = RD_REQ;
              end
            end
            OP_STORE: begin
              state_d = DONE;
              done_d  = 1'b1;
              if (lock_q[cmd_core] && (tag_q[cmd_core] != cmd_ptr)) begin
                err_d = 1'b1;
              end else begin
                tag_d[cmd_core]   = cmd_ptr;
                val_d[cmd_core]   = cmd_data;
                valid_d[cmd_core] = 1'b1;
              end
            end
            OP_LOCK: begin
              // LOCK toggles: a second LOCK releases the entry and reports hit
              state_d = DONE;
              done_d  = 1'b1;
              if (lock_q[cmd_core]) begin
                lock_d[cmd_core] = 1'b0;
                hit_d            = 1'b1;
              end else begin
                lock_d[cmd_core] = 1'b1;
                if (!valid_q[cmd_core]) begin
                  tag_d[cmd_core] = cmd_ptr;
                end else begin
                  tag_d[cmd_core] = tag_q[cmd_core];
                end
              end
            end
            OP_FLUSH: begin
              if (valid_q[cmd_core]) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = tag_q[cmd_core];
                wr_data_d  = val_q[cmd_core];
                state_d    = WR_REQ;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (mem_rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (mem_resp_valid) begin
          val_d[cur_q]   = mem_resp_data;
          valid_d[cur_q] = 1'b1;
          retr_d[cur_q]  = 1'b0;
          state_d        = DONE;
          done_d         = 1'b1;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR_REQ: begin
        if (mem_wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = DONE;
          done_d     = 1'b1;
        end else begin
          state_d = WR_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      valid_q    <= '0;
      retr_q     <= '0;
      lock_q     <= '0;
      tag_q      <= '0;
      val_q      <= '0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      valid_q    <= valid_d;
      retr_q     <= retr_d;
      lock_q     <= lock_d;
      tag_q      <= tag_d;
      val_q      <= val_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // done_q is only ever set on entry to DONE, so IDLE alone means no pulse pending
  assign cmd_ready    = (state_q == IDLE) && !done_q;
  assign done         = done_q;
  assign hit          = hit_q;
  assign err          = err_q;
  assign mem_rd_valid = rd_valid_q;
  assign mem_rd_addr  = rd_addr_q;
  assign mem_wr_valid = wr_valid_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;

  for (genvar i = 0; i < NCORES; i++) begin : g_pack
    assign rf_out[i*EW +: EW] = {valid_q[i], retr_q[i], lock_q[i], tag_q[i], val_q[i]};
  end

endmodule

// File: tb/tb_rf_bank.sv
// Directed self-checking bench for rf_bank: hand-computed expectations checked with immediate assertions.
module tb_rf_bank;
  localparam int NCORES = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CW     = 2;
  localparam int EW     = 3 + ADDR_W + DATA_W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CW-1:0]        cmd_core;
  logic [1:0]           cmd_op;
  logic [ADDR_W-1:0]    cmd_ptr;
  logic [DATA_W-1:0]    cmd_data;
  logic                 done, hit, err;
  logic                 mem_rd_valid, mem_rd_ready;
  logic [ADDR_W-1:0]    mem_rd_addr;
  logic                 mem_resp_valid;
  logic [DATA_W-1:0]    mem_resp_data;
  logic                 mem_wr_valid, mem_wr_ready;
  logic [ADDR_W-1:0]    mem_wr_addr;
  logic [DATA_W-1:0]    mem_wr_data;
  logic [NCORES*EW-1:0] rf_out;

  int n_total = 0;
  int n_pass  = 0;

  rf_bank #(.NCORES(NCORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_core(cmd_core),
    .cmd_op(cmd_op), .cmd_ptr(cmd_ptr), .cmd_data(cmd_data),
    .done(done), .hit(hit), .err(err),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .rf_out(rf_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [EW-1:0] ent(input int i);
    return rf_out[i*EW +: EW];
  endfunction

  function automatic logic [EW-1:0] mk(input logic v, input logic r, input logic l,
                                       input logic [ADDR_W-1:0] t, input logic [DATA_W-1:0] d);
    return {v, r, l, t, d};
  endfunction

  task automatic issue(input logic [CW-1:0] core, input logic [1:0] op,
                       input logic [ADDR_W-1:0] ptr, input logic [DATA_W-1:0] data);
    cmd_valid = 1'b1;
    cmd_core  = core;
    cmd_op    = op;
    cmd_ptr   = ptr;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_core = '0; cmd_op = 2'b00;
    cmd_ptr = '0; cmd_data = '0; mem_rd_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = '0; mem_wr_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_rf_out", 64'(rf_out == '0), 64'd1);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_valid", 64'(mem_rd_valid), 64'd0);
    check("rst_wr_valid", 64'(mem_wr_valid), 64'd0);

    // LOAD miss on core 1
    issue(2'd1, 2'b00, 16'h0010, 16'h0000);
    check("miss_rd_valid", 64'(mem_rd_valid), 64'd1);
    check("miss_rd_addr", 64'(mem_rd_addr), 64'h0010);
    check("miss_entry_retr", 64'(ent(1)), 64'(mk(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000)));
    check("miss_ready_low", 64'(cmd_ready), 64'd0);
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
    check("wait_rd_valid_low", 64'(mem_rd_valid), 64'd0);
    check("wait_retr", 64'(ent(1)), 64'(mk(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000)));
    mem_resp_valid = 1'b1; mem_resp_data = 16'h00AB;
    tick();
    mem_resp_valid = 1'b0;
    check("miss_done", 64'(done), 64'd1);
    check("miss_hit", 64'(hit), 64'd0);
    check("miss_err", 64'(err), 64'd0);
    check("miss_entry_fill", 64'(ent(1)), 64'(mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h00AB)));
    check("done_ready_low", 64'(cmd_ready), 64'd0);
    tick();
    check("done_pulse_one", 64'(done), 64'd0);
    check("ready_back", 64'(cmd_ready), 64'd1);

    // LOAD hit
    issue(2'd1, 2'b00, 16'h0010, 16'h0000);
    check("hit_done", 64'(done), 64'd1);
    check("hit_hit", 64'(hit), 64'd1);
    check("hit_no_rd", 64'(mem_rd_valid), 64'd0);
    check("hit_entry", 64'(ent(1)), 64'(mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h00AB)));
    tick();

    // STORE core 2 then FLUSH with write backpressure
    issue(2'd2, 2'b01, 16'h0020, 16'h1234);
    check("st_done", 64'(done), 64'd1);
    check("st_flags", 64'({hit, err}), 64'd0);
    check("st_entry", 64'(ent(2)), 64'(mk(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234)));
    check("st_no_wr", 64'(mem_wr_valid), 64'd0);
    tick();
    issue(2'd2, 2'b11, 16'h0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      check("fl_wr_valid", 64'(mem_wr_valid), 64'd1);
      check("fl_wr_addr", 64'(mem_wr_addr), 64'h0020);
      check("fl_wr_data", 64'(mem_wr_data), 64'h1234);
      check("fl_no_done", 64'(done), 64'd0);
      tick();
    end
    mem_wr_ready = 1'b1;
    tick();
    mem_wr_ready = 1'b0;
    check("fl_done", 64'(done), 64'd1);
    check("fl_wr_drop", 64'(mem_wr_valid), 64'd0);
    check("fl_entry_kept", 64'(ent(2)), 64'(mk(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234)));
    tick();

    // LOCK core 0, rejected LOAD, unlock
    issue(2'd0, 2'b10, 16'h0005, 16'h0000);
    check("lk_done", 64'(done), 64'd1);
    check("lk_flags", 64'({hit, err}), 64'd0);
    check("lk_entry", 64'(ent(0)), 64'(mk(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000)));
    tick();
    issue(2'd0, 2'b00, 16'h0006, 16'h0000);
    check("lk_ld_done", 64'(done), 64'd1);
    check("lk_ld_err", 64'({hit, err}), 64'b01);
    check("lk_ld_no_rd", 64'(mem_rd_valid), 64'd0);
    check("lk_ld_entry", 64'(ent(0)), 64'(mk(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000)));
    tick();
    issue(2'd0, 2'b10, 16'h0077, 16'h0000);
    check("unlk_flags", 64'({hit, err}), 64'b10);
    check("unlk_entry", 64'(ent(0)), 64'(mk(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000)));
    tick();

    // Read backpressure with a competing command
    issue(2'd3, 2'b00, 16'h0030, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      check("bp_rd_valid", 64'(mem_rd_valid), 64'd1);
      check("bp_rd_addr", 64'(mem_rd_addr), 64'h0030);
      check("bp_ready_low", 64'(cmd_ready), 64'd0);
      cmd_valid = 1'b1; cmd_core = 2'd0; cmd_op = 2'b01; cmd_ptr = 16'h0099; cmd_data = 16'hBEEF;
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_rd_held", 64'(mem_rd_valid), 64'd1);
    check("bp_cmd_ignored", 64'(ent(0)), 64'(mk(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000)));
    check("bp_iso_e1", 64'(ent(1)), 64'(mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h00AB)));
    check("bp_no_done", 64'(done), 64'd0);
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
    check("bp_rd_wait", 64'(ent(3)), 64'(mk(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000)));

    // Reset during RD_WAIT, then a stray response
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_rf_out", 64'(rf_out == '0), 64'd1);
    check("mr_rd_valid", 64'(mem_rd_valid), 64'd0);
    check("mr_ready", 64'(cmd_ready), 64'd1);
    mem_resp_valid = 1'b1; mem_resp_data = 16'h00FF;
    tick();
    mem_resp_valid = 1'b0;
    check("mr_no_done", 64'(done), 64'd0);
    check("mr_rf_still0", 64'(rf_out == '0), 64'd1);
    check("mr_ready_idle", 64'(cmd_ready), 64'd1);
    tick();
    check("mr_no_done2", 64'(done), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rf_bank.md
Name: rf_bank

Overview:
- Stateful per-core cell cache for the threadbrain cores, NCORES entries.
- Each entry holds valid, retrieving, locked, a tag (memory pointer) and a value.
- Serves one command at a time from the core scheduler and fills misses from data memory through a single read/write port.
- Exposes the whole bank as a packed vector in the existing per-entry field layout, so current field-extract logic keeps working unchanged.

Parameters:
- NCORES, 4, number of entries (one per core); must be >= 2.
- ADDR_W, 16, tag / memory pointer width.
- DATA_W, 16, cell value width.
- Derived: CW = $clog2(NCORES); EW = 3+ADDR_W+DATA_W.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bank can accept a command.
- cmd_core  in  CW  target entry.
- cmd_op  in  2  00 LOAD, 01 STORE, 10 LOCK, 11 FLUSH.
- cmd_ptr  in  ADDR_W  memory pointer.
- cmd_data  in  DATA_W  STORE data.
- done  out  1  one-cycle completion pulse.
- hit  out  1  valid with done: LOAD hit.
- err  out  1  valid with done: command rejected.
- mem_rd_valid  out  1  read request.
- mem_rd_ready  in  1  read request accepted.
- mem_rd_addr  out  ADDR_W  read address.
- mem_resp_valid  in  1  read data valid.
- mem_resp_data  in  DATA_W  read data.
- mem_wr_valid  out  1  write request.
- mem_wr_ready  in  1  write accepted.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  DATA_W  write data.
- rf_out  out  NCORES*EW  packed bank. Entry i occupies bits [i*EW +: EW]; MSB to LSB: valid, retrieving, locked, tag[ADDR_W], val[DATA_W].

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-low. On a clk edge with rst_n=0, every entry field is cleared to 0, the FSM goes to IDLE, and done/hit/err/mem_rd_valid/mem_wr_valid are 0.
  - Memory address/data outputs are 0 in reset.
- Handshakes:
  - cmd_ready = (state==IDLE) and no done pulse pending. A command is accepted on an edge with cmd_valid && cmd_ready.
  - Memory request strobes (mem_rd_valid, mem_wr_valid) hold steady, with stable address/data, until their ready is seen.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
  - DONE lasts one cycle: done=1 with hit/err registered, cmd_ready=0, then return to IDLE. Every command's done pulse is therefore at least one cycle after acceptance.
- LOAD:
  - Hit (valid=1 and tag==cmd_ptr): no change, go to DONE with hit=1.
  - Locked entry with tag!=cmd_ptr: no change, DONE with err=1.
  - Otherwise (miss): on acceptance set valid=0, retrieving=1, tag=cmd_ptr; go to RD_REQ with mem_rd_valid=1, mem_rd_addr=cmd_ptr.
  - RD_REQ: when mem_rd_ready=1, go to RD_WAIT (mem_rd_valid=0 next cycle).
  - RD_WAIT: when mem_resp_valid=1, set val=mem_resp_data, valid=1, retrieving=0, then DONE with hit=0.
  - mem_resp_valid arriving in any other state is ignored.
- STORE:
  - Locked entry with tag!=cmd_ptr: err=1, no change.
  - Else set tag=cmd_ptr, val=cmd_data, valid=1. Entry is local only; memory is not written.
  - Then DONE.
- LOCK:
  - If already locked, err=1 and no change.
  - Else set locked=1 and, when valid=0, tag=cmd_ptr.
  - cmd_ptr is ignored on a valid entry.
  - A second LOCK on a locked entry is the unlock request: it clears locked and reports err=0, hit=1.
  - Net effect: LOCK toggles. Result flags: lock returns hit=0 err=0; unlock returns hit=1 err=0. The err case above does not occur.
- FLUSH:
  - valid=1: WR_REQ with mem_wr_valid=1, addr=tag, data=val; on mem_wr_ready go to DONE.
  - valid=0: DONE immediately, no memory traffic.
  - The entry is unchanged by FLUSH.
- Entry isolation: only the addressed entry changes; all others hold.
- rf_out reflects register state, with no combinational path from cmd_*.
- Reset mid-operation: asserting reset in RD_REQ/RD_WAIT/WR_REQ abandons the transaction, with strobes low the next cycle. A late mem_resp_valid after reset is ignored.
- Widths: tag compare is full ADDR_W; no arithmetic on tag or val.

Test Plan:
- Reset then LOAD core 1 ptr 0x0010 (miss): mem_rd_valid with addr 0x0010; response 0x00AB gives done, hit=0, entry1 = {1,0,0,0x0010,0x00AB}; retrieving=1 during the wait.
- Repeat LOAD core 1 ptr 0x0010: done 1 cycle after acceptance, hit=1, no mem_rd_valid.
- STORE core 2 ptr 0x0020 data 0x1234, then FLUSH core 2: mem_wr addr 0x0020 data 0x1234. Hold mem_wr_ready low 3 cycles and check the strobe stays stable.
- LOCK core 0 at ptr 0x0005, then LOAD core 0 ptr 0x0006: err=1, entry0 unchanged, no memory read. Second LOCK gives hit=1, locked=0.
- Backpressure: mem_rd_ready low 4 cycles. mem_rd_valid and addr stay held, cmd_ready=0 throughout, and a cmd_valid during this time is not accepted.
- Assert rst_n=0 during RD_WAIT, then pulse mem_resp_valid: all entries 0, state IDLE, no done pulse.
